pwm_duty_ramp: RTL
==================

PWM_DUTY_RAMP -- requirements
Module: pwm_duty_ramp

Interface
REQ-001 Parameter N, default 4: duty resolution; the duty output spans 0..2^N, where 2^N means full on.
REQ-002 Parameter TICK_W, default 20: width of the step-period divisor.
REQ-003 The port list SHALL be exactly:
  - clk  input  1  rising-edge clock; the only clock.
  - reset  input  1  synchronous, active-low reset.
  - start  input  1  request to begin ramping; level-sampled.
  - stop  input  1  request to end after the current full cycle; level-sampled.
  - step_period  input  TICK_W  clocks per ramp step; 0 is treated as 1.
  - hold_steps  input  8  extra steps to dwell at peak and at floor.
  - duty  output  N+1  duty command for the downstream PWM stage.
  - busy  output  1  high in any state other than IDLE.
  - at_peak  output  1  high while in HOLD_HI.
  - cycle_done  output  1  one-clock pulse when a down-ramp reaches 0.

Function
REQ-004 The FSM SHALL have exactly five states: IDLE, UP, HOLD_HI, DOWN and HOLD_LO.
REQ-005 The prescaler SHALL count 0..P-1, where P = max(step_period, 1).
  - tick is asserted in the cycle the count equals P-1.
  - The count wraps to 0 on the following edge.
  - In IDLE the count is held at 0.
REQ-006 step_period SHALL be sampled continuously; a change takes effect at the next wrap, or immediately if the count is already at or above the new P-1.
REQ-007 In IDLE, start=1 with stop=0 SHALL move the FSM to UP with duty=0 and prescaler=0 at the next edge; start together with stop SHALL leave the FSM in IDLE.
REQ-008 In UP, on each tick duty SHALL increment by 1; the edge at which duty becomes 2^N SHALL also move the FSM to HOLD_HI with hold_cnt=0.
REQ-009 In HOLD_HI and HOLD_LO, on each tick:
  - if hold_cnt == hold_steps, leave the state;
  - otherwise increment hold_cnt.
  - The dwell is therefore hold_steps+1 ticks.
REQ-010 HOLD_HI SHALL exit to DOWN.
REQ-011 In DOWN, on each tick duty SHALL decrement by 1; the edge at which duty becomes 0 SHALL move the FSM to HOLD_LO with hold_cnt=0 and SHALL assert cycle_done for exactly one clock following that edge.
REQ-012 HOLD_LO SHALL exit to IDLE if stop_pending=1; otherwise it SHALL exit to UP.
REQ-013 stop=1 in any non-IDLE state SHALL set stop_pending.
  - stop_pending is cleared on entry to IDLE.
  - stop never truncates a ramp.
REQ-014 start SHALL be ignored outside IDLE.
REQ-015 duty SHALL be registered and SHALL never exceed 2^N or go below 0; no wrap-around at either bound.
REQ-016 Ramp latency: duty first becomes 1 exactly P clocks after the start edge; a full up-ramp takes 2^N*P clocks.
REQ-017 busy, at_peak and cycle_done SHALL be registered or decoded from registered state only, with no combinational path from inputs.

Reset
REQ-018 While reset=0 at a rising clk edge, the block SHALL set:
  - FSM = IDLE;
  - duty = 0, prescaler = 0, hold_cnt = 0;
  - stop_pending = 0;
  - busy = 0, at_peak = 0, cycle_done = 0.
REQ-019 Reset asserted mid-ramp SHALL take effect at that edge; duty returns to 0 with no intermediate values.
REQ-020 After reset deasserts, the block SHALL stay in IDLE until start is seen.

Structure
REQ-021 The state enum typedef and a DUTY_MAX(N) constant function SHALL live in shared package pwm_pkg, which is also used by the downstream PWM stage.
REQ-022 The prescaler SHALL be a sub-module, pwm_tick_gen, with ports clk, reset, en, period and tick.
REQ-023 duty SHALL connect directly to the downstream PWM stage's duty-control input of width N+1.

Verification
REQ-024 Basic cycle, with N=4, step_period=2, hold_steps=1 and a start pulse at edge 0:
  - duty=1 at edge 2 and 16 at edge 32;
  - at_peak from edge 32 to edge 36;
  - duty=15 at edge 38 and 0 at edge 68;
  - cycle_done high for exactly one clock after edge 68.
REQ-025 stop pulsed mid-UP: the full up/down cycle completes, then HOLD_LO runs, then IDLE; busy=0 and duty=0 afterwards, and cycle_done is seen once.
REQ-026 step_period=0 behaves identically to step_period=1: duty reaches 16 at 16 clocks after start; hold_steps=0 gives a one-tick dwell.
REQ-027 start and stop asserted together in IDLE: the FSM stays in IDLE and busy stays 0; start asserted in DOWN changes nothing.
REQ-028 reset=0 applied while duty=9 in UP: at the next edge duty=0, the FSM is IDLE and all outputs are 0; a new start afterwards ramps from 0.
REQ-029 Free-running mode with stop=0 for three cycles: at no time is duty > 16 or duty < 0, cycle_done pulses exactly three times, and UP and DOWN never skip a value.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: definitions shared by the duty ramp generator and the downstream
// PWM stage that consumes its duty command.
//   ramp_state_t : ramp FSM state encoding
//   DUTY_MAX(n)  : full-on duty value for an n-bit resolution (2^n)
package pwm_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        UP      = 3'd1,
        HOLD_HI = 3'd2,
        DOWN    = 3'd3,
        HOLD_LO = 3'd4
    } ramp_state_t;

    function automatic int unsigned DUTY_MAX(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// pwm_tick_gen: ramp step prescaler. Counts 0..P-1 with P = max(period,1)
// and flags the last count as a tick; held at 0 while disabled.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-low reset
//   en     in   count enable (low holds the count at 0)
//   period in   clocks per tick; 0 behaves as 1
//   tick   out  high in the cycle the count reaches P-1
module pwm_tick_gen #(
    parameter int TICK_W = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [TICK_W-1:0] period,
    output logic              tick
);

    localparam logic [TICK_W-1:0] CNT_ONE = TICK_W'(1);

    logic [TICK_W-1:0] r_cnt;
    logic [TICK_W-1:0] w_last;

    // period is live: comparing with >= makes a shortened period take
    // effect at once when the count has already passed the new terminal.
    assign w_last = (period == '0) ? '0 : period - CNT_ONE;
    assign tick   = en && (r_cnt >= w_last);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (!en || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: triangular duty-cycle ramp generator. Ramps duty 0 -> 2^N,
// dwells at peak, ramps back to 0, dwells at floor, and repeats until a stop
// request has been seen, then returns to IDLE.
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-low reset
//   start       in   begin ramping (honoured only in IDLE, and not with stop)
//   stop        in   finish after the current full cycle
//   step_period in   clocks per ramp step (0 behaves as 1)
//   hold_steps  in   extra steps to dwell at peak and at floor
//   duty        out  registered duty command, 0..2^N
//   busy        out  high whenever not IDLE
//   at_peak     out  high while in HOLD_HI
//   cycle_done  out  one-clock pulse after a down-ramp reaches 0
module pwm_duty_ramp
    import pwm_pkg::*;
#(
    parameter int N      = 4,
    parameter int TICK_W = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [TICK_W-1:0] step_period,
    input  logic [7:0]        hold_steps,
    output logic [N:0]        duty,
    output logic              busy,
    output logic              at_peak,
    output logic              cycle_done
);

    localparam logic [N:0] DMAX     = (N+1)'(DUTY_MAX(N));
    localparam logic [N:0] DUTY_ONE = (N+1)'(1);

    ramp_state_t r_state, w_state_nxt;
    logic [N:0]  r_duty,  w_duty_nxt;
    logic [7:0]  r_hold,  w_hold_nxt;
    logic        r_pend,  w_pend_nxt;
    logic        r_done,  w_done_nxt;
    logic        w_tick;
    logic        w_en;

    assign w_en = (r_state != IDLE);

    pwm_tick_gen #(
        .TICK_W (TICK_W)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .en     (w_en),
        .period (step_period),
        .tick   (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_duty <= '0;
            r_hold <= '0;
            r_pend <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_duty <= w_duty_nxt;
            r_hold <= w_hold_nxt;
            r_pend <= w_pend_nxt;
            r_done <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty;
        w_hold_nxt  = r_hold;
        w_pend_nxt  = r_pend;
        w_done_nxt  = 1'b0;

        // Stop is only latched; the exit decision in HOLD_LO uses the value
        // registered before the exit edge.
        if (r_state != IDLE && stop) begin
            w_pend_nxt = 1'b1;
        end

        case (r_state)
            IDLE: begin
                w_pend_nxt = 1'b0;
                if (start && !stop) begin
                    w_state_nxt = UP;
                    w_duty_nxt  = '0;
                    w_hold_nxt  = '0;
                end
            end
            UP: begin
                if (w_tick && r_duty != DMAX) begin
                    w_duty_nxt = r_duty + DUTY_ONE;
                    if (r_duty == DMAX - DUTY_ONE) begin
                        w_state_nxt = HOLD_HI;
                        w_hold_nxt  = '0;
                    end
                end
            end
            HOLD_HI: begin
                if (w_tick) begin
                    if (r_hold == hold_steps) begin
                        w_state_nxt = DOWN;
                    end else begin
                        w_hold_nxt = r_hold + 8'd1;
                    end
                end
            end
            DOWN: begin
                if (w_tick && r_duty != '0) begin
                    w_duty_nxt = r_duty - DUTY_ONE;
                    if (r_duty == DUTY_ONE) begin
                        w_state_nxt = HOLD_LO;
                        w_hold_nxt  = '0;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            HOLD_LO: begin
                if (w_tick) begin
                    if (r_hold == hold_steps) begin
                        w_hold_nxt = '0;
                        if (r_pend) begin
                            w_state_nxt = IDLE;
                            w_pend_nxt  = 1'b0;
                        end else begin
                            w_state_nxt = UP;
                            w_duty_nxt  = '0;
                        end
                    end else begin
                        w_hold_nxt = r_hold + 8'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_duty_nxt  = '0;
                w_hold_nxt  = '0;
                w_pend_nxt  = 1'b0;
            end
        endcase
    end

    assign duty       = r_duty;
    assign busy       = (r_state != IDLE);
    assign at_peak    = (r_state == HOLD_HI);
    assign cycle_done = r_done;

endmodule
